// File: rtl/alu_seq_pkg.sv
// Shared types and op decode for the nibble-serial ALU sequencer.
// Imported by the interface and the sequencer core.
package alu_seq_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_ADC = 3'd1,
        OP_SUB = 3'd2,
        OP_SBC = 3'd3,
        OP_AND = 3'd4,
        OP_XOR = 3'd5,
        OP_OR  = 3'd6,
        OP_CP  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        FN_ADD = 2'd0,
        FN_AND = 2'd1,
        FN_XOR = 2'd2,
        FN_OR  = 2'd3
    } alu_fn_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOADA = 3'd1,
        S_LOW   = 3'd2,
        S_HIGH  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        alu_fn_t fn;
        logic    ne;
        logic    uses_cin;
        logic    is_sub;
        logic    is_cp;
    } op_ctl_t;

    function automatic op_ctl_t op_decode(alu_op_t op);
        op_ctl_t c;
        c = '{fn: FN_ADD, ne: 1'b0, uses_cin: 1'b0,
              is_sub: 1'b0, is_cp: 1'b0};
        unique case (op)
            OP_ADD: ;
            OP_ADC: c.uses_cin = 1'b1;
            OP_SUB: begin
                c.ne     = 1'b1;
                c.is_sub = 1'b1;
            end
            OP_SBC: begin
                c.ne       = 1'b1;
                c.uses_cin = 1'b1;
                c.is_sub   = 1'b1;
            end
            OP_AND: c.fn = FN_AND;
            OP_XOR: c.fn = FN_XOR;
            OP_OR:  c.fn = FN_OR;
            OP_CP: begin
                c.ne     = 1'b1;
                c.is_sub = 1'b1;
                c.is_cp  = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request, response and ALU control bundle of the sequencer.
// slave = sequencer view, master = decode/ALU/consumer view.
interface alu_seq_if;
    import alu_seq_pkg::*;

    logic                req_valid;
    logic                req_ready;
    alu_op_t             req_op;
    logic [DATA_W-1:0]   req_a;
    logic [DATA_W-1:0]   req_b;
    logic                req_cin;

    logic [DATA_W-1:0]   alu_bus;
    logic                alu_la;
    logic                alu_lb;
    logic                alu_l;
    logic                alu_h;
    logic                alu_ne;
    alu_fn_t             alu_fn;
    logic                alu_ci;
    logic                alu_res_oe;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_carry;
    logic                alu_zero;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_result;
    logic                rsp_z;
    logic                rsp_n;
    logic                rsp_h;
    logic                rsp_c;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin,
        output req_ready,
        output alu_bus, alu_la, alu_lb, alu_l, alu_h,
        output alu_ne, alu_fn, alu_ci, alu_res_oe,
        input  alu_result, alu_carry, alu_zero,
        output rsp_valid, rsp_result,
        output rsp_z, rsp_n, rsp_h, rsp_c,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_cin,
        input  req_ready,
        input  alu_bus, alu_la, alu_lb, alu_l, alu_h,
        input  alu_ne, alu_fn, alu_ci, alu_res_oe,
        output alu_result, alu_carry, alu_zero,
        input  rsp_valid, rsp_result,
        input  rsp_z, rsp_n, rsp_h, rsp_c,
        output rsp_ready
    );

endinterface

// File: rtl/alu_seq.sv
// Sequencer for the nibble-serial 8-bit ALU: load A, low, high.
// Owns the half-carry latch and returns result plus Z/N/H/C.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic       clk,
    input  logic       nreset,
    alu_seq_if.slave   s
);

    if (W != DATA_W) begin : g_w_check
        $error("alu_seq: W must be 8, the ALU is two 4-bit halves");
    end

    state_t            state;
    alu_op_t           op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              cin_q;
    logic              hc;

    op_ctl_t           ctl;
    logic              accept;
    logic              low_ci;

    logic [DATA_W-1:0] res_n;
    logic              z_n;
    logic              n_n;
    logic              h_n;
    logic              c_n;

    assign ctl = op_decode(op_q);

    assign s.req_ready = (state == S_IDLE) ||
                         (state == S_DONE && s.rsp_ready);

    assign accept = s.req_valid && s.req_ready;

    // SBC borrows when cin is set, so its carry-in is the inverse.
    assign low_ci = ctl.uses_cin ? (cin_q ^ ctl.is_sub) : ctl.is_sub;

    // Response flags from the high-nibble step; carry means no-borrow on subtract.
    always_comb begin
        res_n = ctl.is_cp ? a_q : s.alu_result;
        z_n   = s.alu_zero;
        n_n   = ctl.is_sub;
        h_n   = 1'b0;
        c_n   = 1'b0;
        unique case (1'b1)
            ctl.is_sub: begin
                h_n = !hc;
                c_n = !s.alu_carry;
            end
            (!ctl.is_sub && ctl.fn == FN_ADD): begin
                h_n = hc;
                c_n = s.alu_carry;
            end
            (ctl.fn == FN_AND): h_n = 1'b1;
            default: ;
        endcase
    end

    // Step FSM; ALU strokes are registered one cycle ahead of their step.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= S_IDLE;
            op_q         <= OP_ADD;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            hc           <= 1'b0;
            s.alu_bus    <= '0;
            s.alu_la     <= 1'b0;
            s.alu_lb     <= 1'b0;
            s.alu_l      <= 1'b0;
            s.alu_h      <= 1'b0;
            s.alu_ne     <= 1'b0;
            s.alu_fn     <= FN_ADD;
            s.alu_ci     <= 1'b0;
            s.alu_res_oe <= 1'b0;
            s.rsp_valid  <= 1'b0;
            s.rsp_result <= '0;
            s.rsp_z      <= 1'b0;
            s.rsp_n      <= 1'b0;
            s.rsp_h      <= 1'b0;
            s.rsp_c      <= 1'b0;
        end else begin
            s.alu_bus    <= '0;
            s.alu_la     <= 1'b0;
            s.alu_lb     <= 1'b0;
            s.alu_l      <= 1'b0;
            s.alu_h      <= 1'b0;
            s.alu_ne     <= 1'b0;
            s.alu_fn     <= FN_ADD;
            s.alu_ci     <= 1'b0;
            s.alu_res_oe <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_DONE && s.rsp_ready) begin
                        s.rsp_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                    if (accept) begin
                        op_q      <= s.req_op;
                        a_q       <= s.req_a;
                        b_q       <= s.req_b;
                        cin_q     <= s.req_cin;
                        s.alu_bus <= s.req_a;
                        s.alu_la  <= 1'b1;
                        state     <= S_LOADA;
                    end
                end
                S_LOADA: begin
                    s.alu_bus <= b_q;
                    s.alu_lb  <= 1'b1;
                    s.alu_l   <= 1'b1;
                    s.alu_fn  <= ctl.fn;
                    s.alu_ne  <= ctl.ne;
                    s.alu_ci  <= low_ci;
                    state     <= S_LOW;
                end
                S_LOW: begin
                    hc           <= s.alu_carry;
                    s.alu_h      <= 1'b1;
                    s.alu_res_oe <= 1'b1;
                    s.alu_fn     <= ctl.fn;
                    s.alu_ne     <= ctl.ne;
                    s.alu_ci     <= s.alu_carry;
                    state        <= S_HIGH;
                end
                S_HIGH: begin
                    s.rsp_valid  <= 1'b1;
                    s.rsp_result <= res_n;
                    s.rsp_z      <= z_n;
                    s.rsp_n      <= n_n;
                    s.rsp_h      <= h_n;
                    s.rsp_c      <= c_n;
                    state        <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The two nibble steps never overlap.
    a_lh_excl: assert property (
        @(posedge clk) disable iff (!nreset) !(s.alu_l && s.alu_h)
    );

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: nibble ALU model, arithmetic reference,
// directed cases, back-pressure, reset abort and random ops.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk;
    logic nreset;
    int   n_chk;
    int   n_fail;

    alu_seq_if ifc ();

    alu_seq #(.W(8)) dut (
        .clk    (clk),
        .nreset (nreset),
        .s      (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- nibble ALU model ----------------
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic [7:0] m_opb;
    logic [3:0] m_lo;
    logic [3:0] m_an;
    logic [3:0] m_bn;
    logic [4:0] m_nib;

    always_comb begin
        m_opb = ifc.alu_lb ? ifc.alu_bus : m_b;
        m_an  = ifc.alu_h ? m_a[7:4] : m_a[3:0];
        m_bn  = ifc.alu_h ? m_opb[7:4] : m_opb[3:0];
        if (ifc.alu_ne) m_bn = ~m_bn;
        case (ifc.alu_fn)
            FN_ADD:  m_nib = {1'b0, m_an} + {1'b0, m_bn} + {4'b0, ifc.alu_ci};
            FN_AND:  m_nib = {1'b0, m_an & m_bn};
            FN_XOR:  m_nib = {1'b0, m_an ^ m_bn};
            default: m_nib = {1'b0, m_an | m_bn};
        endcase
        ifc.alu_carry  = (ifc.alu_l || ifc.alu_h) &&
                         (ifc.alu_fn == FN_ADD) && m_nib[4];
        ifc.alu_result = ifc.alu_res_oe ? {m_nib[3:0], m_lo} : 8'h00;
        ifc.alu_zero   = ifc.alu_res_oe && ({m_nib[3:0], m_lo} == 8'h00);
    end

    always_ff @(posedge clk) begin
        if (ifc.alu_la) m_a <= ifc.alu_bus;
        if (ifc.alu_lb) m_b <= ifc.alu_bus;
        if (ifc.alu_l)  m_lo <= m_nib[3:0];
    end

    logic [16:0] alu_pk;
    assign alu_pk = {ifc.alu_bus, ifc.alu_la, ifc.alu_lb, ifc.alu_l,
                     ifc.alu_h, ifc.alu_ne, ifc.alu_fn, ifc.alu_ci,
                     ifc.alu_res_oe};

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void ref_op(input logic [2:0] op,
                                   input logic [7:0] a,
                                   input logic [7:0] b,
                                   input logic cin,
                                   output logic [7:0] res,
                                   output logic [3:0] flg,
                                   output logic hci);
        int ai, bi, k, s, lo;
        logic [7:0] r;
        logic z, n, h, c;
        ai = int'(a);
        bi = int'(b);
        n = 1'b0; h = 1'b0; c = 1'b0; hci = 1'b0;
        r = 8'h00;
        case (op)
            3'd0, 3'd1: begin
                k  = (op == 3'd1) ? int'(cin) : 0;
                s  = ai + bi + k;
                lo = (ai % 16) + (bi % 16) + k;
                r  = 8'(s);
                c  = s > 255;
                h  = lo > 15;
                hci = h;
            end
            3'd2, 3'd3, 3'd7: begin
                k  = (op == 3'd3) ? int'(cin) : 0;
                s  = ai - bi - k;
                lo = (ai % 16) - (bi % 16) - k;
                r  = 8'(s);
                c  = s < 0;
                h  = lo < 0;
                n  = 1'b1;
                hci = !h;
            end
            3'd4: begin r = a & b; h = 1'b1; end
            3'd5: r = a ^ b;
            default: r = a | b;
        endcase
        z   = (r == 8'h00);
        res = (op == 3'd7) ? a : r;
        flg = {z, n, h, c};
    endfunction

    // Expected low-step controls: {fn, ne, ci}.
    function automatic logic [3:0] exp_low(input logic [2:0] op,
                                           input logic cin);
        case (op)
            3'd1:    return {2'd0, 1'b0, cin};
            3'd2:    return {2'd0, 1'b1, 1'b1};
            3'd3:    return {2'd0, 1'b1, !cin};
            3'd4:    return {2'd1, 1'b0, 1'b0};
            3'd5:    return {2'd2, 1'b0, 1'b0};
            3'd6:    return {2'd3, 1'b0, 1'b0};
            3'd7:    return {2'd0, 1'b1, 1'b1};
            default: return 4'd0;
        endcase
    endfunction

    logic [7:0] exp_res;
    logic [3:0] exp_flg;

    // Caller sits at a negedge; leaves the DUT in DONE.
    task automatic run_op(input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic cin,
                          input bit b2b);
        logic       hci;
        logic [3:0] lw;
        int         lat;
        ref_op(op, a, b, cin, exp_res, exp_flg, hci);
        lw = exp_low(op, cin);
        ifc.req_op    = alu_op_t'(op);
        ifc.req_a     = a;
        ifc.req_b     = b;
        ifc.req_cin   = cin;
        ifc.req_valid = 1'b1;
        if (b2b) ifc.rsp_ready = 1'b1;
        #1;
        check("acc_ready", 32'(ifc.req_ready), 32'd1);
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
        ifc.rsp_ready = 1'b0;
        ifc.req_op    = alu_op_t'($urandom_range(7, 0));
        ifc.req_a     = 8'($urandom);
        ifc.req_b     = 8'($urandom);
        ifc.req_cin   = 1'($urandom);
        @(negedge clk);
        check("la_strb", 32'({ifc.alu_la, ifc.alu_lb, ifc.alu_l,
                              ifc.alu_h, ifc.alu_res_oe}), 32'h10);
        check("la_bus", 32'(ifc.alu_bus), 32'(a));
        check("la_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("la_req_ready", 32'(ifc.req_ready), 32'd0);
        @(negedge clk);
        check("lo_strb", 32'({ifc.alu_la, ifc.alu_lb, ifc.alu_l,
                              ifc.alu_h, ifc.alu_res_oe}), 32'h0c);
        check("lo_bus", 32'(ifc.alu_bus), 32'(b));
        check("lo_ctl", 32'({ifc.alu_fn, ifc.alu_ne, ifc.alu_ci}),
              32'(lw));
        @(negedge clk);
        check("hi_strb", 32'({ifc.alu_la, ifc.alu_lb, ifc.alu_l,
                              ifc.alu_h, ifc.alu_res_oe}), 32'h03);
        check("hi_bus", 32'(ifc.alu_bus), 32'd0);
        check("hi_ctl", 32'({ifc.alu_fn, ifc.alu_ne, ifc.alu_ci}),
              32'({lw[3:1], hci}));
        lat = 3;
        do begin
            @(negedge clk);
            lat++;
        end while (!ifc.rsp_valid && lat < 12);
        check("latency", 32'(lat), 32'd4);
        check("rsp_result", 32'(ifc.rsp_result), 32'(exp_res));
        check("rsp_znhc", 32'({ifc.rsp_z, ifc.rsp_n, ifc.rsp_h,
                               ifc.rsp_c}), 32'(exp_flg));
        check("done_alu_idle", 32'(alu_pk), 32'd0);
    endtask

    task automatic take_rsp();
        ifc.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.rsp_ready = 1'b0;
        @(negedge clk);
        check("tk_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("tk_req_ready", 32'(ifc.req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pend;
        n_chk  = 0;
        n_fail = 0;
        nreset = 1'b0;
        ifc.req_valid = 1'b0;
        ifc.req_op    = OP_ADD;
        ifc.req_a     = 8'h00;
        ifc.req_b     = 8'h00;
        ifc.req_cin   = 1'b0;
        ifc.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_alu", 32'(alu_pk), 32'd0);
        check("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("rst_req_ready", 32'(ifc.req_ready), 32'd1);
        check("rst_rsp", 32'({ifc.rsp_result, ifc.rsp_z, ifc.rsp_n,
                              ifc.rsp_h, ifc.rsp_c}), 32'd0);
        nreset = 1'b1;
        @(negedge clk);

        run_op(3'd0, 8'h3A, 8'hC6, 1'b0, 1'b0);
        take_rsp();
        run_op(3'd3, 8'h10, 8'h01, 1'b1, 1'b0);
        take_rsp();
        run_op(3'd7, 8'h20, 8'h30, 1'b0, 1'b0);
        take_rsp();
        run_op(3'd4, 8'h5A, 8'h0F, 1'b0, 1'b0);
        take_rsp();
        run_op(3'd5, 8'hFF, 8'hFF, 1'b0, 1'b0);

        // back-pressure: response must hold, no new request accepted
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(ifc.rsp_valid), 32'd1);
            check("bp_req_ready", 32'(ifc.req_ready), 32'd0);
            check("bp_result", 32'(ifc.rsp_result), 32'(exp_res));
            check("bp_znhc", 32'({ifc.rsp_z, ifc.rsp_n, ifc.rsp_h,
                                  ifc.rsp_c}), 32'(exp_flg));
        end
        run_op(3'd2, 8'h00, 8'h01, 1'b0, 1'b1);
        take_rsp();

        // reset during the LOW step aborts the op
        ifc.req_op    = OP_ADD;
        ifc.req_a     = 8'h55;
        ifc.req_b     = 8'h22;
        ifc.req_valid = 1'b1;
        @(posedge clk);
        #1;
        ifc.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ra_in_low", 32'(ifc.alu_l), 32'd1);
        nreset = 1'b0;
        #1;
        check("ra_alu", 32'(alu_pk), 32'd0);
        check("ra_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
        check("ra_req_ready", 32'(ifc.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("ra_no_rsp", 32'(ifc.rsp_valid), 32'd0);
        end
        run_op(3'd0, 8'h01, 8'h01, 1'b0, 1'b0);
        take_rsp();

        // random ops, mixing idle gaps and back-to-back issue
        pend = 1'b0;
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            logic [7:0] a, b;
            logic       cin;
            bit         b2b;
            op  = 3'($urandom_range(7, 0));
            a   = 8'($urandom);
            b   = 8'($urandom);
            cin = 1'($urandom);
            b2b = pend && ($urandom_range(1, 0) == 1);
            if (pend && !b2b) begin
                repeat ($urandom_range(2, 0)) @(negedge clk);
                take_rsp();
            end
            run_op(op, a, b, cin, b2b);
            pend = 1'b1;
        end
        take_rsp();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
